// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor. Every prefix level is registered.
// A single global stall freezes the whole pipe while the output is blocked.
module prefix_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             pout,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;

  // Index 0 is the operand stage, indices 1..LEVELS are the prefix levels.
  logic [LEVELS:0]  valid_q, valid_d;
  logic [LEVELS:0]  c0_q, c0_d;
  logic [WIDTH-1:0] g_q    [LEVELS+1];
  logic [WIDTH-1:0] g_d    [LEVELS+1];
  logic [WIDTH-1:0] p_q    [LEVELS+1];
  logic [WIDTH-1:0] p_d    [LEVELS+1];
  logic [WIDTH-1:0] praw_q [LEVELS+1];
  logic [WIDTH-1:0] praw_d [LEVELS+1];
  logic [TAG_W-1:0] tag_q  [LEVELS+1];
  logic [TAG_W-1:0] tag_d  [LEVELS+1];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             pout_q, pout_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  assign b_eff = sub ? ~b : b;
  assign c0_in = sub | cin;
  assign p_in  = a ^ b_eff;
  assign g_in  = a & b_eff;

  always_comb begin
    valid_d = valid_q;
    c0_d    = c0_q;
    for (int k = 0; k <= LEVELS; k++) begin
      g_d[k]    = g_q[k];
      p_d[k]    = p_q[k];
      praw_d[k] = praw_q[k];
      tag_d[k]  = tag_q[k];
    end
    if (!stall) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        g_d[0]    = g_in;
        // The carry-in is folded into bit 0 so the tree needs no extra lane.
        g_d[0][0] = g_in[0] | (p_in[0] & c0_in);
        p_d[0]    = p_in;
        praw_d[0] = p_in;
        c0_d[0]   = c0_in;
        tag_d[0]  = tag_in;
      end
      for (int k = 1; k <= LEVELS; k++) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          praw_d[k] = praw_q[k-1];
          c0_d[k]   = c0_q[k-1];
          tag_d[k]  = tag_q[k-1];
          for (int i = 0; i < WIDTH; i++) begin
            if (i >= (1 << (k-1))) begin
              g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k-1))]);
              p_d[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k-1))];
            end else begin
              g_d[k][i] = g_q[k-1][i];
              p_d[k][i] = p_q[k-1][i];
            end
          end
        end
      end
    end
  end

  // Bubbles leave the result fields untouched so the last result stays visible.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    pout_d      = pout_q;
    tag_out_d   = tag_out_q;
    if (!stall) begin
      out_valid_d = valid_q[LEVELS];
      if (valid_q[LEVELS]) begin
        sum_d[0] = praw_q[LEVELS][0] ^ c0_q[LEVELS];
        for (int i = 1; i < WIDTH; i++) begin
          sum_d[i] = praw_q[LEVELS][i] ^ g_q[LEVELS][i-1];
        end
        cout_d    = g_q[LEVELS][WIDTH-1];
        pout_d    = &p_q[LEVELS];
        tag_out_d = tag_q[LEVELS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c0_q    <= '0;
      for (int k = 0; k <= LEVELS; k++) begin
        g_q[k]    <= '0;
        p_q[k]    <= '0;
        praw_q[k] <= '0;
        tag_q[k]  <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      pout_q      <= 1'b0;
      tag_out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      c0_q    <= c0_d;
      for (int k = 0; k <= LEVELS; k++) begin
        g_q[k]    <= g_d[k];
        p_q[k]    <= p_d[k];
        praw_q[k] <= praw_d[k];
        tag_q[k]  <= tag_d[k];
      end
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      pout_q      <= pout_d;
      tag_out_q   <= tag_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign pout      = pout_q;
  assign tag_out   = tag_out_q;

endmodule
